// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the sram-like to AXI bridge.
//   ch_state_e     : per-channel transaction state
//   DEFAULT_ID_W   : default AXI ID width
//   AXI constants  : fixed burst/len encodings driven on the AXI port
//   axi_size()     : sram size code (0 byte, 1 half, 2 word) to AXI AxSIZE
package sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RD_PEND = 2'd1,
    CH_WR_PEND = 2'd2
  } ch_state_e;

  localparam int DEFAULT_ID_W = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/sram_axi_bridge_arbiter.sv
// Fixed-priority one-hot arbiter: the highest set index of req wins.
//   req : N request lines
//   gnt : one-hot grant (all zero when no request)
module sram_axi_bridge_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  always_comb begin
    gnt = '0;
    // Ascending scan so the last (highest) requester overwrites lower ones.
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: NUM_CH sram-like channels (req/addr_ok/data_ok) onto one
// AXI master port. Channel index doubles as the AXI ID; one outstanding
// transaction per channel; reads to a word with a pending write are held off.
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   ch_req/ch_wr/ch_size/ch_wstrb     per-channel request (flattened vectors)
//   ch_addr/ch_wdata                  per-channel address / write data
//   ch_addr_ok                        request accepted this cycle (combinational)
//   ch_data_ok/ch_rdata               response for the channel (combinational)
//   ar*/r*                            AXI read address / read data channels
//   aw*/w*/b*                         AXI write address / data / response
//   arlen..arprot, awlen..awprot,
//   wid, wlast                        constant AXI fields (single beat INCR)
module sram_axi_bridge
  import sram_axi_bridge_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ID_W   = DEFAULT_ID_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      ch_req,
  input  logic [NUM_CH-1:0]      ch_wr,
  input  logic [2*NUM_CH-1:0]    ch_size,
  input  logic [4*NUM_CH-1:0]    ch_wstrb,
  input  logic [32*NUM_CH-1:0]   ch_addr,
  input  logic [32*NUM_CH-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]      ch_addr_ok,
  output logic [NUM_CH-1:0]      ch_data_ok,
  output logic [32*NUM_CH-1:0]   ch_rdata,
  output logic [ID_W-1:0]        arid,
  output logic [31:0]            araddr,
  output logic [2:0]             arsize,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [3:0]             arlen,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  input  logic [ID_W-1:0]        rid,
  input  logic [31:0]            rdata,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [ID_W-1:0]        awid,
  output logic [31:0]            awaddr,
  output logic [2:0]             awsize,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [3:0]             awlen,
  output logic [1:0]             awburst,
  output logic [1:0]             awlock,
  output logic [3:0]             awcache,
  output logic [2:0]             awprot,
  output logic [ID_W-1:0]        wid,
  output logic [31:0]            wdata,
  output logic [3:0]             wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [ID_W-1:0]        bid,
  input  logic                   bvalid,
  output logic                   bready
);

  ch_state_e             state     [NUM_CH];
  ch_state_e             state_nxt [NUM_CH];
  logic [29:0]           wr_word   [NUM_CH];

  logic [NUM_CH-1:0]     rd_ret;
  logic [NUM_CH-1:0]     wr_ret;
  logic [NUM_CH-1:0]     idle_ok;
  logic [NUM_CH-1:0]     hazard;
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     gnt;

  logic                  sel_wr;
  logic [ID_W-1:0]       sel_id;
  logic [31:0]           sel_addr;
  logic [1:0]            sel_size;
  logic [3:0]            sel_wstrb;
  logic [31:0]           sel_wdata;
  logic                  acc_rd;
  logic                  acc_wr;

  logic                  ar_vld_p1;
  logic [ID_W-1:0]       ar_id_p1;
  logic [31:0]           ar_addr_p1;
  logic [2:0]            ar_size_p1;
  logic                  aw_vld_p1;
  logic [ID_W-1:0]       aw_id_p1;
  logic [31:0]           aw_addr_p1;
  logic [2:0]            aw_size_p1;
  logic                  w_vld_p1;
  logic [31:0]           w_data_p1;
  logic [3:0]            w_strb_p1;

  // Responses, hazard detection and eligibility.
  // Hazards use the registered state, so a read to a word being written is
  // first accepted the cycle after that write's bvalid.
  always_comb begin
    rd_ret  = '0;
    wr_ret  = '0;
    idle_ok = '0;
    hazard  = '0;
    elig    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd_ret[i]  = rvalid && (rid == ID_W'(i)) && (state[i] == CH_RD_PEND);
      wr_ret[i]  = bvalid && (bid == ID_W'(i)) && (state[i] == CH_WR_PEND);
      idle_ok[i] = (state[i] == CH_IDLE) || rd_ret[i] || wr_ret[i];
      for (int j = 0; j < NUM_CH; j++) begin
        if ((state[j] == CH_WR_PEND) && (wr_word[j] == ch_addr[i*32+2 +: 30]))
          hazard[i] = 1'b1;
      end
      if (ch_wr[i])
        elig[i] = !reset && ch_req[i] && idle_ok[i] && !aw_vld_p1 && !w_vld_p1;
      else
        elig[i] = !reset && ch_req[i] && idle_ok[i] && !ar_vld_p1 && !hazard[i];
    end
  end

  sram_axi_bridge_arbiter #(
    .N (NUM_CH)
  ) u_arbiter (
    .req (elig),
    .gnt (gnt)
  );

  assign ch_addr_ok = gnt;

  always_comb begin
    ch_data_ok = '0;
    ch_rdata   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data_ok[i] = !reset && (rd_ret[i] || wr_ret[i]);
      if (rd_ret[i])
        ch_rdata[i*32 +: 32] = rdata;
    end
  end

  // Mux of the granted channel's request fields.
  always_comb begin
    sel_wr    = 1'b0;
    sel_id    = '0;
    sel_addr  = '0;
    sel_size  = '0;
    sel_wstrb = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i]) begin
        sel_wr    = ch_wr[i];
        sel_id    = ID_W'(i);
        sel_addr  = ch_addr[i*32 +: 32];
        sel_size  = ch_size[i*2 +: 2];
        sel_wstrb = ch_wstrb[i*4 +: 4];
        sel_wdata = ch_wdata[i*32 +: 32];
      end
    end
  end

  assign acc_rd = (|gnt) && !sel_wr;
  assign acc_wr = (|gnt) && sel_wr;

  // Channel state machine: next-state.
  // A grant wins over a return, which lets a channel re-issue the cycle it
  // completes.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_nxt[i] = state[i];
      if (gnt[i])
        state_nxt[i] = ch_wr[i] ? CH_WR_PEND : CH_RD_PEND;
      else if (rd_ret[i] || wr_ret[i])
        state_nxt[i] = CH_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++)
        state[i] <= CH_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- stage p1: AR / AW / W slots, presented on AXI the cycle after accept ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_vld_p1 <= 1'b0;
      aw_vld_p1 <= 1'b0;
      w_vld_p1  <= 1'b0;
    end else begin
      if (acc_rd)
        ar_vld_p1 <= 1'b1;
      else if (arready)
        ar_vld_p1 <= 1'b0;
      if (acc_wr)
        aw_vld_p1 <= 1'b1;
      else if (awready)
        aw_vld_p1 <= 1'b0;
      if (acc_wr)
        w_vld_p1 <= 1'b1;
      else if (wready)
        w_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_rd) begin
      ar_id_p1   <= sel_id;
      ar_addr_p1 <= sel_addr;
      ar_size_p1 <= axi_size(sel_size);
    end
    if (acc_wr) begin
      aw_id_p1   <= sel_id;
      aw_addr_p1 <= sel_addr;
      aw_size_p1 <= axi_size(sel_size);
      w_data_p1  <= sel_wdata;
      w_strb_p1  <= sel_wstrb;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt[i] && ch_wr[i])
        wr_word[i] <= ch_addr[i*32+2 +: 30];
    end
  end

  assign arid    = ar_id_p1;
  assign araddr  = ar_addr_p1;
  assign arsize  = ar_size_p1;
  assign arvalid = ar_vld_p1;
  assign awid    = aw_id_p1;
  assign awaddr  = aw_addr_p1;
  assign awsize  = aw_size_p1;
  assign awvalid = aw_vld_p1;
  assign wid     = aw_id_p1;
  assign wdata   = w_data_p1;
  assign wstrb   = w_strb_p1;
  assign wvalid  = w_vld_p1;
  assign wlast   = 1'b1;

  assign rready  = !reset;
  assign bready  = !reset;

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;

  localparam int NUM_CH = 2;
  localparam int ID_W   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NUM_CH-1:0]    ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [2*NUM_CH-1:0]  ch_size;
  logic [4*NUM_CH-1:0]  ch_wstrb;
  logic [32*NUM_CH-1:0] ch_addr, ch_wdata, ch_rdata;
  logic [ID_W-1:0]      arid, awid, wid, rid, bid;
  logic [31:0]          araddr, awaddr, wdata, rdata;
  logic [2:0]           arsize, awsize, arprot, awprot;
  logic [3:0]           arlen, awlen, arcache, awcache, wstrb;
  logic [1:0]           arburst, awburst, arlock, awlock;
  logic                 arvalid, arready, rvalid, rready;
  logic                 awvalid, awready, wvalid, wready, wlast, bvalid, bready;

  sram_axi_bridge #(.NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
    .clk(clk), .reset(reset),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_wstrb(ch_wstrb),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .arlen(arlen), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .awlen(awlen), .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bready(bready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: channel status (0 idle, 1 read pending, 2 write pending),
  // the word address of each pending write, and what each AXI request channel
  // should currently be presenting.
  int          m_state [NUM_CH];
  logic [29:0] m_waddr [NUM_CH];
  bit          ar_occ, aw_occ, w_occ, wr_infl;
  int          ar_id, aw_id, wr_id;
  logic [31:0] ar_addr, aw_addr, w_data;
  logic [2:0]  ar_size, aw_size;
  logic [3:0]  w_strb;
  int          rd_q[$];
  int          b_q[$];
  int          grant, last_grant;
  logic [NUM_CH-1:0] ret;

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) m_state[c] = 0;
    ar_occ = 0; aw_occ = 0; w_occ = 0; wr_infl = 0;
    rd_q.delete(); b_q.delete();
    grant = -1; last_grant = -1;
  endtask

  // Mid-cycle: predict this cycle's combinational outputs and compare.
  task automatic settle();
    int r, b;
    bit hz;
    logic [NUM_CH-1:0] exp_ok;
    #3;
    ret = '0;
    grant = -1;
    if (!reset) begin
      r = int'(rid);
      b = int'(bid);
      if (rvalid && r < NUM_CH && m_state[r] == 1) ret[r] = 1'b1;
      if (bvalid && b < NUM_CH && m_state[b] == 2) ret[b] = 1'b1;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
        if (grant < 0 && ch_req[c] && (m_state[c] == 0 || ret[c])) begin
          if (ch_wr[c]) begin
            if (!aw_occ && !w_occ) grant = c;
          end else begin
            hz = 0;
            for (int k = 0; k < NUM_CH; k++)
              if (m_state[k] == 2 && m_waddr[k] == ch_addr[c*32+2 +: 30]) hz = 1;
            if (!ar_occ && !hz) grant = c;
          end
        end
      end
    end
    exp_ok = '0;
    if (grant >= 0) exp_ok[grant] = 1'b1;
    chk("addr_ok", ch_addr_ok, exp_ok);
    chk("data_ok", ch_data_ok, ret);
    for (int c = 0; c < NUM_CH; c++)
      if (ret[c] && m_state[c] == 1) chk("rdata_route", ch_rdata[c*32 +: 32], rdata);
    chk("arvalid", arvalid, ar_occ);
    if (ar_occ) begin
      chk("arid", arid, ar_id);
      chk("araddr", araddr, ar_addr);
      chk("arsize", arsize, ar_size);
    end
    chk("awvalid", awvalid, aw_occ);
    if (aw_occ) begin
      chk("awid", awid, aw_id);
      chk("awaddr", awaddr, aw_addr);
      chk("awsize", awsize, aw_size);
    end
    chk("wvalid", wvalid, w_occ);
    if (w_occ) begin
      chk("wdata", wdata, w_data);
      chk("wstrb", wstrb, w_strb);
    end
    chk("rready", rready, !reset);
    chk("bready", bready, !reset);
  endtask

  // Advance the model across the coming clock edge, then wait for it.
  task automatic tick();
    if (reset) begin
      model_clear();
    end else begin
      if (ar_occ && arready) begin ar_occ = 0; rd_q.push_back(ar_id); end
      if (aw_occ && awready) aw_occ = 0;
      if (w_occ && wready) w_occ = 0;
      if (wr_infl && !aw_occ && !w_occ) begin b_q.push_back(wr_id); wr_infl = 0; end
      for (int c = 0; c < NUM_CH; c++) if (ret[c]) m_state[c] = 0;
      if (grant >= 0) begin
        if (ch_wr[grant]) begin
          m_state[grant] = 2;
          m_waddr[grant] = ch_addr[grant*32+2 +: 30];
          aw_occ = 1; w_occ = 1; wr_infl = 1; wr_id = grant; aw_id = grant;
          aw_addr = ch_addr[grant*32 +: 32];
          aw_size = {1'b0, ch_size[grant*2 +: 2]};
          w_data  = ch_wdata[grant*32 +: 32];
          w_strb  = ch_wstrb[grant*4 +: 4];
        end else begin
          m_state[grant] = 1;
          ar_occ = 1; ar_id = grant;
          ar_addr = ch_addr[grant*32 +: 32];
          ar_size = {1'b0, ch_size[grant*2 +: 2]};
        end
      end
      last_grant = grant;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_wstrb = '0;
    ch_addr = '0; ch_wdata = '0;
    arready = 0; awready = 0; wready = 0;
    rvalid = 0; rid = '0; rdata = '0; bvalid = 0; bid = '0;
  endtask

  task automatic req_until_accept(input int c, input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      settle();
      if (grant == c) done = 1;
      tick();
    end
    ch_req[c] = 1'b0;
    if (!done) begin
      n_cmp++; n_bad++;
      $error("FAIL accept_timeout ch=%0d observed=not_accepted expected=accepted", c);
    end
  endtask

  initial begin
    int idx, r;
    model_clear();
    idle_in();
    reset = 1;
    @(posedge clk); #1;
    settle(); tick();
    settle(); tick();
    reset = 0;
    chk("arburst", arburst, 2'b01);
    chk("arlen", arlen, 4'd0);
    chk("wlast", wlast, 1'b1);

    // 1: ch0 single read
    ch_req = 2'b01; ch_wr = 2'b00; ch_size[1:0] = 2'd2; ch_addr[31:0] = 32'h1c000000; arready = 1;
    settle(); chk("t1_addr_ok", ch_addr_ok, 2'b01); tick();
    ch_req = 2'b00;
    settle(); chk("t1_arvalid", arvalid, 1'b1); chk("t1_arid", arid, 4'd0); chk("t1_arsize", arsize, 3'd2); tick();
    arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h02800000;
    settle(); chk("t1_data_ok", ch_data_ok, 2'b01); chk("t1_rdata", ch_rdata[31:0], 32'h02800000); tick();
    rvalid = 0;
    settle(); tick();

    // 2: simultaneous reads, ch1 wins, ch0 waits for the AR slot
    idle_in();
    ch_req = 2'b11; ch_size = 4'b1010; ch_addr = {32'h00000300, 32'h00000200};
    settle(); chk("t2_ch1_first", ch_addr_ok, 2'b10); tick();
    ch_req = 2'b01;
    settle(); chk("t2_ch0_stall_a", ch_addr_ok, 2'b00); tick();
    settle(); tick();
    arready = 1;
    settle(); chk("t2_ch0_stall_hs", ch_addr_ok[0], 1'b0); tick();
    settle(); chk("t2_ch0_accept", ch_addr_ok, 2'b01); tick();
    ch_req = 2'b00;
    settle(); tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hcafe0001;
    settle(); chk("t2_ret1", ch_data_ok, 2'b10); tick();
    rid = 4'd0; rdata = 32'hcafe0000;
    settle(); chk("t2_ret0", ch_data_ok, 2'b01); tick();
    rvalid = 0;
    settle(); tick();

    // 3: ch1 write with a slow awready
    idle_in();
    ch_req = 2'b10; ch_wr = 2'b10; ch_size[3:2] = 2'd1; ch_wstrb[7:4] = 4'b0011;
    ch_addr[63:32] = 32'h00001000; ch_wdata[63:32] = 32'ha5a51234; wready = 1;
    settle(); chk("t3_addr_ok", ch_addr_ok, 2'b10); tick();
    ch_req = 2'b00;
    settle(); chk("t3_aw_t1", awvalid, 1'b1); chk("t3_w_t1", wvalid, 1'b1);
    chk("t3_awsize", awsize, 3'd1); chk("t3_wstrb", wstrb, 4'b0011); tick();
    settle(); chk("t3_w_clear", wvalid, 1'b0); chk("t3_aw_hold2", awvalid, 1'b1); tick();
    settle(); chk("t3_aw_hold3", awvalid, 1'b1); tick();
    awready = 1;
    settle(); chk("t3_aw_hold4", awvalid, 1'b1); tick();
    awready = 0; bvalid = 1; bid = 4'd1;
    settle(); chk("t3_aw_clear", awvalid, 1'b0); chk("t3_b_ok", ch_data_ok, 2'b10); tick();
    bvalid = 0;
    settle(); tick();

    // 4: read-after-write hazard on the same word
    idle_in();
    awready = 1; wready = 1; arready = 1;
    ch_req = 2'b10; ch_wr = 2'b10; ch_size = 4'b0101; ch_wstrb[7:4] = 4'b1100;
    ch_addr = {32'h00002004, 32'h00002006}; ch_wdata[63:32] = 32'h11223344;
    req_until_accept(1, 4);
    settle(); tick();
    ch_req[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("t4_blocked", ch_addr_ok[0], 1'b0); tick();
    end
    bvalid = 1; bid = 4'd1;
    settle(); chk("t4_blocked_bvalid", ch_addr_ok[0], 1'b0); chk("t4_b_ok", ch_data_ok, 2'b10); tick();
    bvalid = 0;
    settle(); chk("t4_accept_after_b", ch_addr_ok[0], 1'b1); tick();
    ch_req = 2'b00;
    settle(); tick();
    rvalid = 1; rid = 4'd0; rdata = 32'h11220000;
    settle(); chk("t4_read_ret", ch_data_ok, 2'b01); tick();
    rvalid = 0;

    // 5: out-of-order read returns
    idle_in();
    arready = 1; ch_size = 4'b1010; ch_addr = {32'h00000500, 32'h00000400};
    ch_req = 2'b01;
    req_until_accept(0, 4);
    ch_req[1] = 1'b1;
    req_until_accept(1, 6);
    settle(); tick();
    arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h55550001;
    settle(); chk("t5_rid1", ch_data_ok, 2'b10); chk("t5_rdata1", ch_rdata[63:32], 32'h55550001); tick();
    rid = 4'd0; rdata = 32'h44440000;
    settle(); chk("t5_rid0", ch_data_ok, 2'b01); chk("t5_rdata0", ch_rdata[31:0], 32'h44440000); tick();
    rvalid = 0;
    settle(); tick();

    // 6: reset while a read is pending; late response is dropped
    idle_in();
    ch_req = 2'b01; ch_size[1:0] = 2'd2; ch_addr[31:0] = 32'h00000600;
    req_until_accept(0, 4);
    settle(); chk("t6_arvalid_pre", arvalid, 1'b1); tick();
    reset = 1;
    settle(); tick();
    settle(); chk("t6_addr_ok_rst", ch_addr_ok, 2'b00); tick();
    reset = 0;
    settle(); chk("t6_arvalid_post", arvalid, 1'b0); tick();
    rvalid = 1; rid = 4'd0; rdata = 32'hdeadbeef;
    settle(); chk("t6_late_rvalid", ch_data_ok, 2'b00); tick();
    rvalid = 0;

    // Randomized traffic against the model
    idle_in();
    reset = 1;
    settle(); tick();
    reset = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (last_grant == c) begin
          ch_req[c] = 1'b0;
        end else if (!ch_req[c] && $urandom_range(0, 2) == 0) begin
          ch_req[c] = 1'b1;
          ch_wr[c] = 1'($urandom_range(0, 1));
          ch_size[c*2 +: 2] = 2'($urandom_range(0, 2));
          ch_wstrb[c*4 +: 4] = 4'($urandom);
          ch_addr[c*32 +: 32] = 32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
          ch_wdata[c*32 +: 32] = $urandom;
        end
      end
      arready = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      rvalid = 0;
      if (rd_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, rd_q.size() - 1);
        rid = ID_W'(rd_q[idx]);
        rd_q.delete(idx);
        rdata = $urandom;
        rvalid = 1;
      end else if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 15);
        if (!(r < NUM_CH && m_state[r] == 1)) begin
          rid = ID_W'(r); rdata = $urandom; rvalid = 1;
        end
      end
      bvalid = 0;
      if (b_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, b_q.size() - 1);
        bid = ID_W'(b_q[idx]);
        b_q.delete(idx);
        bvalid = 1;
      end else if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 15);
        if (!(r < NUM_CH && m_state[r] == 2)) begin
          bid = ID_W'(r); bvalid = 1;
        end
      end
      settle();
      tick();
    end
    idle_in();
    settle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
